pll_reset_ce_gen: RTL and testbench



---
 rtl/pll_reset_ce_gen_if.sv | 25 ++
 rtl/pll_reset_ce_gen.sv | 162 ++++++++++++++++
 tb/tb_pll_reset_ce_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_ce_gen_if.sv
// rtl/pll_reset_ce_gen_if.sv - reset and clock-enable bundle driven by pll_reset_ce_gen
// master drives the reset/enable outputs, slave is the consuming core side.
interface pll_reset_ce_gen_if;
  logic       sys_reset_n;
  logic       ce_pix;
  logic       ce_cpu;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  modport master (
    output sys_reset_n,
    output ce_pix,
    output ce_cpu,
    output ready,
    output lock_loss_cnt
  );

  modport slave (
    input sys_reset_n,
    input ce_pix,
    input ce_cpu,
    input ready,
    input lock_loss_cnt
  );
endinterface

// File: rtl/pll_reset_ce_gen.sv
// rtl/pll_reset_ce_gen.sv - debounced lock-to-reset sequencer with fractional pixel/CPU enables
// Optional lock-drop counter enabled by defining PLL_LOCK_LOSS_COUNT_EN.
module pll_reset_ce_gen #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 64,
  parameter int PIX_INC            = 1536,
  parameter int PIX_MOD            = 59786,
  parameter int ACC_W              = 17,
  parameter int CPU_DIV            = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_lock,
  pll_reset_ce_gen_if.master ctl
);

  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int DIV_W  = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t             state;
  logic [STAB_W-1:0]  stab_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               sync_q1;
  logic               lock_s;
  logic               sys_reset_n_q;
  logic               ready_q;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sum;
  logic               wrap;
  logic [DIV_W-1:0]   div_cnt;
  logic               ce_pix_q;
  logic               ce_cpu_q;
  logic               stab_done;
  logic               hold_done;
  logic               acc_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync_q1 <= pll_lock;
      lock_s  <= sync_q1;
    end
  end

  assign stab_done = (stab_cnt == STAB_W'(LOCK_STABLE_CYCLES - 1));
  assign hold_done = (hold_cnt == HOLD_W'(RST_HOLD_CYCLES - 1));

  // The accumulator runs on exactly the edges whose next state is HOLD or RUN,
  // so the registered enables never appear outside those states.
  assign acc_en = lock_s && ((state == STABLE && stab_done) || state == HOLD || state == RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= WAIT_LOCK;
      stab_cnt      <= '0;
      hold_cnt      <= '0;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      case (state)
        WAIT_LOCK: begin
          stab_cnt <= '0;
          hold_cnt <= '0;
          if (lock_s) begin
            state <= STABLE;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else if (stab_done) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else if (hold_done) begin
            state         <= RUN;
            sys_reset_n_q <= 1'b1;
            ready_q       <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else begin
            sys_reset_n_q <= 1'b1;
            ready_q       <= 1'b1;
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

  assign sum  = acc + ACC_W'(PIX_INC);
  assign wrap = (sum >= ACC_W'(PIX_MOD));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      div_cnt  <= '0;
      ce_pix_q <= 1'b0;
      ce_cpu_q <= 1'b0;
    end else if (!acc_en) begin
      acc      <= '0;
      div_cnt  <= '0;
      ce_pix_q <= 1'b0;
      ce_cpu_q <= 1'b0;
    end else if (wrap) begin
      acc      <= sum - ACC_W'(PIX_MOD);
      ce_pix_q <= 1'b1;
      ce_cpu_q <= (div_cnt == '0);
      div_cnt  <= (div_cnt == DIV_W'(CPU_DIV - 1)) ? '0 : div_cnt + 1'b1;
    end else begin
      acc      <= sum;
      ce_pix_q <= 1'b0;
      ce_cpu_q <= 1'b0;
    end
  end

`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0] loss_q;

  // Only a drop out of RUN counts; debounce and hold aborts are expected noise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_q <= 8'd0;
    end else if (state == RUN && !lock_s && loss_q != 8'hFF) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign ctl.lock_loss_cnt = loss_q;
`else
  assign ctl.lock_loss_cnt = 8'd0;
`endif

  assign ctl.sys_reset_n = sys_reset_n_q;
  assign ctl.ready       = ready_q;
  assign ctl.ce_pix      = ce_pix_q;
  assign ctl.ce_cpu      = ce_cpu_q;

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// tb/tb_pll_reset_ce_gen.sv - self-checking bench for pll_reset_ce_gen
// Model tracks the run length of synchronised lock and derives every output from it.
module tb_pll_reset_ce_gen;

  localparam int N   = 8;
  localparam int H   = 4;
  localparam int INC = 3;
  localparam int MOD = 10;
  localparam int DIV = 2;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic pll_lock = 1'b0;

  always #5 clk = ~clk;

  pll_reset_ce_gen_if ctl ();

  pll_reset_ce_gen #(
    .LOCK_STABLE_CYCLES(N),
    .RST_HOLD_CYCLES   (H),
    .PIX_INC           (INC),
    .PIX_MOD           (MOD),
    .ACC_W             (5),
    .CPU_DIV           (DIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pll_lock(pll_lock),
    .ctl     (ctl)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: r_m = number of consecutive edges that saw synchronised lock high.
  int   r_m    = 0;
  int   loss_m = 0;
  logic h1     = 1'b0;
  logic h2     = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m    <= 0;
      loss_m <= 0;
      h1     <= 1'b0;
      h2     <= 1'b0;
    end else begin
      h1 <= pll_lock;
      h2 <= h1;
      if (h2) begin
        r_m <= r_m + 1;
      end else begin
        if (r_m >= N + H + 1 && loss_m < 255) loss_m <= loss_m + 1;
        r_m <= 0;
      end
    end
  end

  function automatic int pulses(input int k);
    return (k <= 0) ? 0 : (k * INC) / MOD;
  endfunction

  int   k_c;
  logic run_c;
  logic pix_c;
  logic cpu_c;
  int   loss_c;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_sys_reset_n", int'(ctl.sys_reset_n), 0);
      check("rst_ce_pix", int'(ctl.ce_pix), 0);
      check("rst_lock_loss_cnt", int'(ctl.lock_loss_cnt), 0);
    end else begin
      k_c   = r_m - N;
      run_c = (k_c >= H + 1);
      pix_c = (k_c >= 1) && (pulses(k_c) != pulses(k_c - 1));
      cpu_c = pix_c && (((pulses(k_c) - 1) % DIV) == 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
      loss_c = loss_m;
`else
      loss_c = 0;
`endif
      check("sys_reset_n", int'(ctl.sys_reset_n), int'(run_c));
      check("ready", int'(ctl.ready), int'(run_c));
      check("ce_pix", int'(ctl.ce_pix), int'(pix_c));
      check("ce_cpu", int'(ctl.ce_cpu), int'(cpu_c));
      check("lock_loss_cnt", int'(ctl.lock_loss_cnt), loss_c);
    end
  end

  // Edges until the selected output reaches level; -1 if the bound expires.
  task automatic edges_until(input int which, input logic level, output int n);
    bit hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (which == 0) hit = (ctl.sys_reset_n == level);
      else            hit = (ctl.ce_pix == level);
    end
    if (!hit) n = -1;
  endtask

  task automatic run_drop();
    @(negedge clk);
    pll_lock = 1'b0;
    repeat (4) @(negedge clk);
    pll_lock = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  int exp_loss_small;
  int exp_loss_sat;

  initial begin
    int n, first_rst, first_rdy, first_pix, pix_pre, pix_cnt, cpu_cnt;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    exp_loss_small = 4;
    exp_loss_sat   = 255;
`else
    exp_loss_small = 0;
    exp_loss_sat   = 0;
`endif
    reset_n  = 1'b0;
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", int'({ctl.sys_reset_n, ctl.ready, ctl.ce_pix, ctl.ce_cpu}), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Lock up from cold; HOLD covers edges 11..14, RUN from edge 15.
    pll_lock  = 1'b1;
    first_rst = 0; first_rdy = 0; first_pix = 0;
    pix_pre   = 0; pix_cnt = 0; cpu_cnt = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (ctl.sys_reset_n && first_rst == 0) first_rst = e;
      if (ctl.ready && first_rdy == 0) first_rdy = e;
      if (ctl.ce_pix && first_pix == 0) first_pix = e;
      if (e <= 10) pix_pre += int'(ctl.ce_pix);
      else begin
        pix_cnt += int'(ctl.ce_pix);
        cpu_cnt += int'(ctl.ce_cpu);
      end
    end
    check("first_sys_reset_n_edge", first_rst, 15);
    check("first_ready_edge", first_rdy, 15);
    check("first_ce_pix_edge", first_pix, 14);
    check("ce_pix_before_hold", pix_pre, 0);
    check("ce_pix_30_cycles", pix_cnt, 9);
    check("ce_cpu_30_cycles", cpu_cnt, 5);

    pix_cnt = 0; cpu_cnt = 0;
    for (int e = 0; e < 100; e++) begin
      @(posedge clk);
      #1;
      pix_cnt += int'(ctl.ce_pix);
      cpu_cnt += int'(ctl.ce_cpu);
    end
    check("ce_pix_100_cycles", pix_cnt, 30);
    check("ce_cpu_100_cycles", cpu_cnt, 15);

    // One-cycle glitch mid-debounce restarts the whole sequence.
    @(negedge clk);
    pll_lock = 1'b0;
    repeat (5) @(negedge clk);
    pll_lock = 1'b1;
    repeat (6) @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    edges_until(0, 1'b1, n);
    check("glitch_release_edge", n, 15);

    // Lock drop in RUN.
    repeat (3) @(negedge clk);
    pll_lock = 1'b0;
    edges_until(0, 1'b0, n);
    check("drop_latency_le3", int'(n >= 1 && n <= 3), 1);
    check("drop_ready_low", int'(ctl.ready), 0);
    repeat (3) @(negedge clk);
    pll_lock = 1'b1;
    edges_until(1, 1'b1, n);
    check("relock_first_ce_pix_edge", n, 14);

    // Asynchronous reset in RUN.
    repeat (5) @(negedge clk);
    check("pre_reset_run", int'(ctl.sys_reset_n), 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({ctl.sys_reset_n, ctl.ready, ctl.ce_pix, ctl.ce_cpu}), 0);
    check("async_reset_loss", int'(ctl.lock_loss_cnt), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    edges_until(0, 1'b1, n);
    check("post_reset_release_edge", n, 15);

    // Lock-loss counting: four RUN drops, then STABLE and HOLD drops that must not count.
    repeat (3) run_drop();
    @(negedge clk);
    pll_lock = 1'b0;
    repeat (4) @(negedge clk);
    pll_lock = 1'b1;
    repeat (6) @(negedge clk);
    pll_lock = 1'b0;
    repeat (4) @(negedge clk);
    pll_lock = 1'b1;
    repeat (12) @(negedge clk);
    pll_lock = 1'b0;
    repeat (4) @(negedge clk);
    check("loss_after_stable_hold_drops", int'(ctl.lock_loss_cnt), exp_loss_small);
    pll_lock = 1'b1;
    repeat (16) @(negedge clk);
    repeat (296) run_drop();
    check("loss_saturated", int'(ctl.lock_loss_cnt), exp_loss_sat);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule
